// File: rtl/route_arbiter_if.sv
// ============================================================================
//  Module      : route_arbiter_if
//  Description : Source-FIFO, destination-FIFO and status bundle for the
//                two-source / two-destination route arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface route_arbiter_if #(
    parameter int DATA_W = 10
);
    // Source side (show-ahead FIFOs)
    logic              src_empty0;
    logic              src_empty1;
    logic [DATA_W-1:0] src_data0;
    logic [DATA_W-1:0] src_data1;
    logic              pop0;
    logic              pop1;
    // Destination side
    logic              dest_af0;
    logic              dest_af1;
    logic              dest_full0;
    logic              dest_full1;
    logic              push0;
    logic              push1;
    logic [DATA_W-1:0] data_out;
    // Status
    logic              pause;
    logic              idle;
    logic              error;

    // Arbiter side
    modport master (
        input  src_empty0, src_empty1, src_data0, src_data1,
        input  dest_af0, dest_af1, dest_full0, dest_full1,
        output pop0, pop1, push0, push1, data_out, pause, idle, error
    );

    // FIFO / environment side
    modport slave (
        output src_empty0, src_empty1, src_data0, src_data1,
        output dest_af0, dest_af1, dest_full0, dest_full1,
        input  pop0, pop1, push0, push1, data_out, pause, idle, error
    );
endinterface

`default_nettype wire

// File: rtl/route_arbiter.sv
// ============================================================================
//  Module      : route_arbiter
//  Description : Round-robin, burst-bounded scheduler draining two class
//                FIFOs into two destination FIFOs, routed per word by a
//                class bit, with almost-full backpressure and a sticky
//                error on pushes into a full destination.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module route_arbiter #(
    parameter int DATA_W    = 10,
    parameter int DEST_BIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  wire logic       clk,
    input  wire logic       reset,
    route_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pref;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_pref_nx;
    logic [1:0]       w_pop;
    logic [1:0]       w_elig;
    logic             w_own;
    logic [DATA_W-1:0] w_word;
    logic             w_dest;

    // A source is eligible when it has a word and that word's destination
    // is not almost full.
    assign w_elig[0] = !bus.src_empty0 &&
                       !(bus.src_data0[DEST_BIT] ? bus.dest_af1 : bus.dest_af0);
    assign w_elig[1] = !bus.src_empty1 &&
                       !(bus.src_data1[DEST_BIT] ? bus.dest_af1 : bus.dest_af0);

    assign w_own = (r_state == GRANT1);

    // Next-state, burst count, preference and pop selection.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pref_nx  = r_pref;
        w_pop      = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_elig[r_pref]) begin
                    w_pop[r_pref] = 1'b1;
                    w_state_nx    = r_pref ? GRANT1 : GRANT0;
                    w_cnt_nx      = C_ONE;
                end else if (w_elig[~r_pref]) begin
                    w_pop[~r_pref] = 1'b1;
                    w_state_nx     = r_pref ? GRANT0 : GRANT1;
                    w_cnt_nx       = C_ONE;
                end
            end
            GRANT0, GRANT1: begin
                if (w_elig[w_own] && ((r_cnt < C_MAX_BURST) || !w_elig[~w_own])) begin
                    // Owner keeps the grant; count saturates so a lone source
                    // can stream indefinitely.
                    w_pop[w_own] = 1'b1;
                    w_cnt_nx     = (r_cnt >= C_MAX_BURST) ? r_cnt : r_cnt + C_ONE;
                end else if (w_elig[~w_own]) begin
                    // Hand-off in the same cycle: no bubble between bursts.
                    w_pop[~w_own] = 1'b1;
                    w_state_nx    = w_own ? GRANT0 : GRANT1;
                    w_cnt_nx      = C_ONE;
                    w_pref_nx     = w_own;
                end else begin
                    w_state_nx = IDLE;
                    w_pref_nx  = ~w_own;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Pops are blocked outright while reset is held.
    assign bus.pop0 = w_pop[0] & reset;
    assign bus.pop1 = w_pop[1] & reset;

    // Head word of whichever source is popped this cycle, and its target.
    assign w_word = w_pop[1] ? bus.src_data1 : bus.src_data0;
    assign w_dest = w_word[DEST_BIT];

    // Scheduler state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pref  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pref  <= w_pref_nx;
        end
    end

    // Output stage: push the popped word one cycle later, flag full targets,
    // and register the status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.push0    <= 1'b0;
            bus.push1    <= 1'b0;
            bus.data_out <= '0;
            bus.pause    <= 1'b0;
            bus.idle     <= 1'b0;
            bus.error    <= 1'b0;
        end else begin
            bus.push0 <= (|w_pop) && !w_dest;
            bus.push1 <= (|w_pop) &&  w_dest;
            if (|w_pop) begin
                bus.data_out <= w_word;
                if (w_dest ? bus.dest_full1 : bus.dest_full0) begin
                    bus.error <= 1'b1;
                end
            end
            bus.pause <= bus.dest_af0 | bus.dest_af1;
            bus.idle  <= (r_state == IDLE) && bus.src_empty0 && bus.src_empty1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_route_arbiter.sv
// ============================================================================
//  Module      : tb_route_arbiter
//  Description : Directed self-checking bench for route_arbiter. Source FIFOs
//                are modelled as queues; destination flags are driven directly.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_route_arbiter;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    route_arbiter_if #(.DATA_W(10)) bus();

    route_arbiter #(
        .DATA_W    (10),
        .DEST_BIT  (8),
        .MAX_BURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present queue heads on the source ports.
    task automatic refresh();
        bus.src_empty0 = (q0.size() == 0);
        bus.src_data0  = (q0.size() != 0) ? q0[0] : 10'h000;
        bus.src_empty1 = (q0.size() >= 0) && (q1.size() == 0);
        bus.src_data1  = (q1.size() != 0) ? q1[0] : 10'h000;
    endtask

    // Consume popped heads just after each rising edge.
    always @(posedge clk) begin
        logic p0;
        logic p1;
        p0 = bus.pop0;
        p1 = bus.pop1;
        #1;
        if (p0) begin
            if (q0.size() == 0) check("pop0_while_empty", 1, 0);
            else q0.delete(0);
        end
        if (p1) begin
            if (q1.size() == 0) check("pop1_while_empty", 1, 0);
            else q1.delete(0);
        end
        refresh();
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        bus.dest_af0   = 1'b0;
        bus.dest_af1   = 1'b0;
        bus.dest_full0 = 1'b0;
        bus.dest_full1 = 1'b0;
        q0.delete();
        q1.delete();
        refresh();
        step();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        do_reset();

        // ---------------- Reset hold with both sources non-empty ----------
        q0.push_back(10'h011); q0.push_back(10'h022);
        q1.push_back(10'h133); q1.push_back(10'h144);
        refresh();
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst_hold", {bus.pop0, bus.pop1, bus.push0, bus.push1, bus.error,
                               bus.pause, bus.idle, bus.data_out}, 0);
        end
        reset = 1'b1;
        #1;
        check("rst_first_pop", {bus.pop1, bus.pop0}, 2'b01);
        step();
        check("rst_first_push", {bus.push1, bus.push0, bus.data_out}, {2'b01, 10'h011});
        // Reset with a word in the output register: it must be dropped.
        reset = 1'b0;
        #1;
        check("rst_midflight", {bus.push1, bus.push0, bus.data_out}, 0);

        // ---------------- Class routing ----------------------------------
        do_reset();
        q0.push_back(10'h0FF); q0.push_back(10'h1EE);
        refresh();
        reset = 1'b1;
        #1;
        check("route_pop_a", {bus.pop1, bus.pop0}, 2'b01);
        step();
        check("route_push0", {bus.push1, bus.push0, bus.data_out}, {2'b01, 10'h0FF});
        check("route_pop_b", {bus.pop1, bus.pop0}, 2'b01);
        step();
        check("route_push1", {bus.push1, bus.push0, bus.data_out}, {2'b10, 10'h1EE});
        step();
        check("route_hold", {bus.push1, bus.push0, bus.data_out, bus.error}, {2'b00, 10'h1EE, 1'b0});

        // ---------------- Round-robin bursts ------------------------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            q0.push_back(10'(i));
            q1.push_back(10'(16 + i));
        end
        refresh();
        reset = 1'b1;
        #1;
        begin
            logic [15:0] seq;
            int          npops;
            seq   = '0;
            npops = 0;
            for (int i = 0; i < 16; i++) begin
                seq   = {seq[14:0], bus.pop1};
                npops = npops + int'(bus.pop0) + int'(bus.pop1);
                step();
            end
            check("rr_sequence", seq, 16'h0F0F);
            check("rr_no_bubble", npops, 16);
        end
        check("rr_last_word", {bus.push1, bus.push0, bus.data_out}, {2'b01, 10'd23});
        check("rr_drained", {bus.pop1, bus.pop0}, 2'b00);

        // ---------------- Backpressure ------------------------------------
        do_reset();
        bus.dest_af1 = 1'b1;
        q0.push_back(10'h001); q0.push_back(10'h002); q0.push_back(10'h003);
        q1.push_back(10'h101); q1.push_back(10'h102); q1.push_back(10'h103);
        refresh();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_pop_src0", {bus.pop1, bus.pop0}, 2'b01);
            if (i == 1) check("bp_pause_on", bus.pause, 1);
            step();
        end
        check("bp_blocked", {bus.pop1, bus.pop0}, 2'b00);
        bus.dest_af1 = 1'b0;
        #1;
        check("bp_resume", {bus.pop1, bus.pop0}, 2'b10);
        step();
        check("bp_push1", {bus.push1, bus.push0, bus.data_out}, {2'b10, 10'h101});
        check("bp_pause_off", bus.pause, 0);
        step();
        step();
        step();

        // ---------------- Single-source saturation -------------------------
        do_reset();
        for (int i = 0; i < 6; i++) q0.push_back(10'(48 + i));
        refresh();
        reset = 1'b1;
        #1;
        begin
            logic [5:0] seq;
            seq = '0;
            for (int i = 0; i < 6; i++) begin
                seq = {seq[4:0], bus.pop0 & ~bus.pop1};
                step();
            end
            check("sat_six_pops", seq, 6'b111111);
        end
        check("sat_stop", {bus.pop1, bus.pop0}, 2'b00);
        check("sat_last_word", {bus.push0, bus.data_out}, {1'b1, 10'd53});
        step();
        check("sat_idle_lag", bus.idle, 0);
        step();
        check("sat_idle", bus.idle, 1);

        // ---------------- Sticky error ------------------------------------
        do_reset();
        bus.dest_full0 = 1'b1;
        q0.push_back(10'h0AA);
        refresh();
        reset = 1'b1;
        #1;
        check("err_pre", {bus.error, bus.pop1, bus.pop0}, 3'b001);
        step();
        check("err_push", {bus.push1, bus.push0, bus.data_out}, {2'b01, 10'h0AA});
        check("err_set", bus.error, 1);
        bus.dest_full0 = 1'b0;
        repeat (3) step();
        check("err_sticky", bus.error, 1);
        reset = 1'b0;
        #1;
        check("err_cleared", bus.error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
